// File: rtl/bitty_pkg.sv
// Shared types and constants for the Bitty fetch path.
package bitty_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/bitty_instr_ram.sv
// Single-port-write, synchronous-read instruction RAM for the Bitty fetch unit.
// A read that collides with a write to the same address returns the new word.
module bitty_instr_ram
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic [INSTR_W-1:0] rd_data_r;

  // Write port: contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port with write-first bypass so a same-cycle load is visible.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_r <= wr_data;
      end else begin
        rd_data_r <= mem_r[rd_addr];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction supplier for the Bitty core: issues one word at a time from local RAM,
// advancing on done, following taken branches and halting at the programmed last address.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [15:0]        load_data,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic               start,
  input  logic               done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [15:0]        instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               done_err
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t       state_r;
  fetch_state_t       state_next_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_next_s;
  logic [ADDR_W-1:0]  last_q_r;
  logic [ADDR_W-1:0]  last_next_s;
  logic [INSTR_W-1:0] instruction_r;
  logic [INSTR_W-1:0] instruction_next_s;
  logic               instr_valid_r;
  logic               instr_valid_next_s;
  logic               halted_r;
  logic               halted_next_s;
  logic               done_err_r;
  logic               done_err_next_s;
  logic               ram_we_s;
  logic               ram_re_s;
  logic [INSTR_W-1:0] ram_rdata_s;

  bitty_instr_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we_s),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (ram_re_s),
    .rd_addr (pc_next_s),
    .rd_data (ram_rdata_s)
  );

  // State register: synchronous active-low reset aborts any run immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, next-PC and last-address selection.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    last_next_s  = last_q_r;
    case (state_r)
      IDLE, HALT: begin
        if (start) begin
          state_next_s = READ;
          pc_next_s    = {ADDR_W{1'b0}};
          last_next_s  = last_addr;
        end else begin
          state_next_s = state_r;
        end
      end
      READ: begin
        state_next_s = ISSUE;
      end
      ISSUE: begin
        if (done) begin
          // A taken branch wins even when sitting on the last address.
          if (branch_taken) begin
            state_next_s = READ;
            pc_next_s    = branch_target;
          end else if (pc_r == last_q_r) begin
            state_next_s = HALT;
          end else begin
            state_next_s = READ;
            pc_next_s    = pc_r + PC_ONE;
          end
        end else begin
          state_next_s = ISSUE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output and RAM-control decode; the RAM is read on the edge entering READ.
  always_comb begin
    ram_we_s           = load_en && ((state_r == IDLE) || (state_r == HALT));
    ram_re_s           = (state_next_s == READ);
    instr_valid_next_s = (state_next_s == ISSUE);
    halted_next_s      = (state_next_s == HALT);
    done_err_next_s    = done_err_r || (done && (state_r != ISSUE));
    if (state_r == READ) begin
      instruction_next_s = ram_rdata_s;
    end else begin
      instruction_next_s = instruction_r;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r          <= {ADDR_W{1'b0}};
      last_q_r      <= {ADDR_W{1'b0}};
      instruction_r <= 16'h0000;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      done_err_r    <= 1'b0;
    end else begin
      pc_r          <= pc_next_s;
      last_q_r      <= last_next_s;
      instruction_r <= instruction_next_s;
      instr_valid_r <= instr_valid_next_s;
      halted_r      <= halted_next_s;
      done_err_r    <= done_err_next_s;
    end
  end

  assign instruction = instruction_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign halted      = halted_r;
  assign done_err    = done_err_r;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Directed self-checking bench for bitty_fetch_unit with a cycle-level program model.
module tb_bitty_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [7:0]  last_addr;
  logic        start;
  logic        done;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  logic        done_err;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  bitty_fetch_unit #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .last_addr     (last_addr),
    .start         (start),
    .done          (done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .halted        (halted),
    .done_err      (done_err)
  );

  always #5 clk = ~clk;

  // Model: program memory plus "running" view (fetch pending / instruction on offer / stopped).
  logic [15:0] m_mem [256];
  logic [15:0] m_instr;
  logic        m_valid;
  logic [7:0]  m_pc;
  logic [7:0]  m_last;
  logic        m_halted;
  logic        m_err;
  logic        m_fetch;

  always @(posedge clk) begin
    if (!reset) begin
      m_instr = 16'h0000; m_valid = 1'b0; m_pc = 8'd0; m_last = 8'd0;
      m_halted = 1'b0; m_err = 1'b0; m_fetch = 1'b0;
    end else if (m_fetch) begin
      if (done) m_err = 1'b1;
      m_instr = m_mem[m_pc];
      m_valid = 1'b1;
      m_fetch = 1'b0;
    end else if (m_valid) begin
      if (done) begin
        m_valid = 1'b0;
        if (branch_taken) begin
          m_pc = branch_target; m_fetch = 1'b1;
        end else if (m_pc == m_last) begin
          m_halted = 1'b1;
        end else begin
          m_pc = 8'((int'(m_pc) + 1) % 256); m_fetch = 1'b1;
        end
      end
    end else begin
      if (load_en) m_mem[load_addr] = load_data;
      if (done) m_err = 1'b1;
      if (start) begin
        m_pc = 8'd0; m_last = last_addr; m_halted = 1'b0; m_fetch = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("m_instr",  {16'd0, instruction}, {16'd0, m_instr});
      check("m_valid",  {31'd0, instr_valid}, {31'd0, m_valid});
      check("m_pc",     {24'd0, pc},          {24'd0, m_pc});
      check("m_halted", {31'd0, halted},      {31'd0, m_halted});
      check("m_err",    {31'd0, done_err},    {31'd0, m_err});
    end
  end

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] last);
    start = 1'b1; last_addr = last;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done(input logic br, input logic [7:0] tgt);
    wait_valid();
    done = 1'b1; branch_taken = br; branch_target = tgt;
    @(negedge clk);
    done = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 16'h0000;
    last_addr = 8'd0; start = 1'b0; done = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'h0000);

    // Load and start: valid two edges after start is sampled
    load(8'd0, 16'h1111); load(8'd1, 16'h2222); load(8'd2, 16'h3333);
    do_start(8'd2);
    check("lat_early", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, instr_valid}, 32'd1);
    check("first_instr", {16'd0, instruction}, 32'h1111);

    // Straight-line run to halt
    pulse_done(1'b0, 8'd0);
    wait_valid();
    check("pc1_instr", {16'd0, instruction}, 32'h2222);
    pulse_done(1'b0, 8'd0);
    wait_valid();
    check("pc2_instr", {16'd0, instruction}, 32'h3333);
    pulse_done(1'b0, 8'd0);
    check("halted_lit", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);

    // Branch back, and branch taken at the last address keeps running
    do_start(8'd2);
    pulse_done(1'b0, 8'd0);
    pulse_done(1'b1, 8'd0);
    wait_valid();
    check("br_pc", {24'd0, pc}, 32'd0);
    check("br_instr", {16'd0, instruction}, 32'h1111);
    pulse_done(1'b0, 8'd0);
    pulse_done(1'b0, 8'd0);
    pulse_done(1'b1, 8'd1);
    wait_valid();
    check("br_last_pc", {24'd0, pc}, 32'd1);
    pulse_done(1'b0, 8'd0);
    pulse_done(1'b0, 8'd0);

    // Top of the address space: halt at 255, then wrap 255 -> 0
    load(8'd255, 16'hAAAA); load(8'd254, 16'hBBBB);
    do_start(8'd255);
    pulse_done(1'b1, 8'd255);
    pulse_done(1'b1, 8'd255);
    wait_valid();
    check("pc255_instr", {16'd0, instruction}, 32'hAAAA);
    pulse_done(1'b0, 8'd0);
    check("halt255", {31'd0, halted}, 32'd1);
    do_start(8'd254);
    pulse_done(1'b1, 8'd255);
    pulse_done(1'b0, 8'd0);
    wait_valid();
    check("wrap_pc", {24'd0, pc}, 32'd0);
    check("wrap_instr", {16'd0, instruction}, 32'h1111);
    pulse_done(1'b1, 8'd254);
    pulse_done(1'b0, 8'd0);
    check("halt254", {31'd0, halted}, 32'd1);

    // Reset in the middle of issuing pc=5
    load(8'd5, 16'h5555);
    do_start(8'd10);
    pulse_done(1'b1, 8'd5);
    wait_valid();
    check("pc5", {24'd0, pc}, 32'd5);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_pc", {24'd0, pc}, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_instr", {16'd0, instruction}, 32'h0000);

    // Stray done in IDLE, ignored load during ISSUE, then load+start together
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("err_set", {31'd0, done_err}, 32'd1);
    check("err_pc", {24'd0, pc}, 32'd0);
    do_start(8'd1);
    wait_valid();
    load(8'd1, 16'hDEAD);
    pulse_done(1'b0, 8'd0);
    wait_valid();
    check("noload_instr", {16'd0, instruction}, 32'h2222);
    pulse_done(1'b0, 8'd0);
    load_en = 1'b1; load_addr = 8'd0; load_data = 16'h7777;
    do_start(8'd0);
    load_en = 1'b0;
    wait_valid();
    check("wfirst_instr", {16'd0, instruction}, 32'h7777);
    pulse_done(1'b0, 8'd0);
    check("err_sticky", {31'd0, done_err}, 32'd1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
